// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant sequencer.
// Imported by the sequencer top and its priority-pick sub-module.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

    function automatic int nreq(input int idx_w);
        return 1 << idx_w;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr.
// Rotates a doubled request vector, then priority-encodes the low half.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter  int IDX_W = 3,
    localparam int NREQ  = nreq(IDX_W)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDX_W-1:0]  off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    // Offset add wraps naturally in IDX_W bits.
    assign idx = ptr + off;
    assign any = |req;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter with registered one-hot grant, hold limit
// and one dead turnaround cycle between owners.
module rr_grant_sequencer
    import arb_pkg::*;
#(
    parameter  int IDX_W    = 3,
    parameter  int MAX_HOLD = 16,
    localparam int NREQ     = nreq(IDX_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int HOLD_W =
        (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic PREEMPT = (MAX_HOLD != 0);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [IDX_W-1:0]  pick;
    logic              any;
    logic              others;
    logic              rel;

    rr_priority_pick #(
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick),
        .any (any)
    );

    assign others = |(req & ~gnt_q);
    assign rel    = done
                  | ~req[idx_q]
                  | (PREEMPT && cnt_q == HOLD_LAST && others);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE, TURN: begin
                gnt_d = '0;
                if (any) begin
                    state_d = GRANT;
                    idx_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (rel) begin
                    // Coincident release causes still advance ptr by one.
                    state_d = TURN;
                    gnt_d   = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Scoreboard bench for rr_grant_sequencer (IDX_W=3, MAX_HOLD=4).
// A cycle model queues expected outputs; they are popped after each edge.
module tb_rr_grant_sequencer;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    rr_grant_sequencer #(
        .IDX_W    (3),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
    } exp_t;

    exp_t q[$];

    int n_chk;
    int n_fail;

    // Reference model state: 0 idle, 1 grant, 2 turn.
    int         m_st;
    logic [2:0] m_ptr;
    logic [2:0] m_idx;
    logic [7:0] m_gnt;
    int         m_cnt;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st  = 0;
        m_ptr = 3'd0;
        m_idx = 3'd0;
        m_gnt = 8'h00;
        m_cnt = 0;
    endtask

    function automatic logic [2:0] m_pick(input logic [7:0] r,
                                          input logic [2:0] p);
        logic [2:0] j;
        for (int k = 0; k < 8; k++) begin
            j = p + 3'(k);
            if (r[j]) return j;
        end
        return 3'd0;
    endfunction

    task automatic m_step(input logic [7:0] r, input logic d);
        logic rel;
        exp_t e;
        if (m_st == 1) begin
            rel = d || !r[m_idx] ||
                  (m_cnt == MH - 1 && (r & ~m_gnt) != 8'h00);
            if (rel) begin
                m_st  = 2;
                m_gnt = 8'h00;
                m_ptr = m_idx + 3'd1;
            end else if (m_cnt < MH - 1) begin
                m_cnt++;
            end
        end else if (r != 8'h00) begin
            m_idx = m_pick(r, m_ptr);
            m_gnt = 8'h01 << m_idx;
            m_cnt = 0;
            m_st  = 1;
        end else begin
            m_st  = 0;
            m_gnt = 8'h00;
        end
        e.g = m_gnt;
        e.i = m_idx;
        e.v = (m_gnt != 8'h00);
        q.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] r, input logic d);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        m_step(r, d);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check("gnt", 32'(gnt), 32'(e.g));
            check("gnt_idx", 32'(gnt_idx), 32'(e.i));
            check("gnt_valid", 32'(gnt_valid), 32'(e.v));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        done   = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a grant is held drops it without a clock edge.
        repeat (3) cyc(8'h01, 1'b0);
        check("pre_rst_gnt", 32'(gnt), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_valid", 32'(gnt_valid), 32'h0);
        m_reset();
        @(negedge clk);
        req   = 8'h01;
        rst_n = 1'b1;
        cyc(8'h01, 1'b0);
        check("post_rst_gnt", 32'(gnt), 32'h01);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);

        // Full rotation, one-cycle tenures separated by turnarounds.
        do_reset();
        for (int k = 0; k < 18; k++) cyc(8'hFF, 1'b1);

        // Preemption between two waiting requesters.
        do_reset();
        for (int k = 0; k < 14; k++) cyc(8'h05, 1'b0);

        // Lone requester saturates, then a newcomer preempts at once.
        do_reset();
        for (int k = 0; k < 20; k++) cyc(8'h01, 1'b0);
        check("lone_gnt", 32'(gnt), 32'h01);
        for (int k = 0; k < 6; k++) cyc(8'h05, 1'b0);

        // Pointer wraps from 7 to 0.
        do_reset();
        cyc(8'h80, 1'b0);
        cyc(8'h80, 1'b0);
        cyc(8'h81, 1'b1);
        check("wrap_turn", 32'(gnt), 32'h00);
        cyc(8'h81, 1'b0);
        check("wrap_gnt", 32'(gnt), 32'h01);

        // done and owner drop together: one turnaround, ptr moves by one.
        do_reset();
        cyc(8'h02, 1'b0);
        cyc(8'h05, 1'b1);
        check("dual_turn", 32'(gnt), 32'h00);
        cyc(8'h05, 1'b0);
        check("dual_gnt", 32'(gnt), 32'h04);
        for (int k = 0; k < 4; k++) cyc(8'h00, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            cyc(8'($urandom_range(0, 255)),
                1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
